tx_fifo_mux: RTL and testbench

Parametrised multi-channel transmit buffer on the `txusrclk` domain. It holds NUM_CH independent single-clock FIFOs, each DATA_W wide and 2^DEPTH_LOG2 deep. A round-robin arbiter drains them one word per cycle into the transceiver TX path whenever `tx_ready` is high. It adds per-channel flush, sticky overflow flags, a channel tag on output, and optional idle-word fill, none of which the single-channel controller provides.

---
 rtl/tx_fifo_mux_if.sv | 31 +++
 rtl/tx_fifo_mux.sv | 169 ++++++++++++++++
 tb/tb_tx_fifo_mux.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_fifo_mux_if.sv
// Bus bundle for tx_fifo_mux: channel write side, TX pop side and status.
// The master drives channel data and controls; the slave is the mux itself.
interface tx_fifo_mux_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH*DATA_W-1:0] datain;
    logic [NUM_CH-1:0]        datain_valid;
    logic [NUM_CH-1:0]        clr;
    logic                     tx_ready;
    logic                     idle_fill;
    logic [NUM_CH-1:0]        fifo_full;
    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH-1:0]        overflow;
    logic [DATA_W-1:0]        dataout;
    logic                     dataout_valid;
    logic [CH_W-1:0]          dataout_ch;

    modport master (
        output datain, datain_valid, clr, tx_ready, idle_fill,
        input  fifo_full, fifo_empty, overflow,
        input  dataout, dataout_valid, dataout_ch
    );

    modport slave (
        input  datain, datain_valid, clr, tx_ready, idle_fill,
        output fifo_full, fifo_empty, overflow,
        output dataout, dataout_valid, dataout_ch
    );
endinterface

// File: rtl/tx_fifo_mux.sv
// Multi-channel TX buffer: NUM_CH single-clock FIFOs drained one word
// per cycle by a round-robin arbiter into a registered TX output.
module tx_fifo_mux #(
    parameter int              DATA_W     = 16,
    parameter int              DEPTH_LOG2 = 4,
    parameter int              NUM_CH     = 4,
    parameter logic [DATA_W-1:0] IDLE_WORD = 16'h50BC
) (
    input  logic         txusrclk,
    input  logic         rst_n,
    tx_fifo_mux_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(NUM_CH - 1);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];

    ptr_t wr_ptr_q [NUM_CH];
    ptr_t wr_ptr_d [NUM_CH];
    ptr_t rd_ptr_q [NUM_CH];
    ptr_t rd_ptr_d [NUM_CH];
    cnt_t cnt_q    [NUM_CH];
    cnt_t cnt_d    [NUM_CH];

    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop_ch;

    logic [CH_W-1:0] last_grant_q;
    logic [CH_W-1:0] last_grant_d;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] arb_idx;
    logic            grant_vld;
    logic            pop;

    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              dvalid_q;
    logic              dvalid_d;
    logic [CH_W-1:0]   dch_q;
    logic [CH_W-1:0]   dch_d;

    always_comb begin
        full  = '0;
        empty = '0;
        elig  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]  = (cnt_q[c] == FULL_CNT);
            empty[c] = (cnt_q[c] == '0);
            elig[c]  = !empty[c] && !bus.clr[c];
        end
    end

    // Search starts one past the last served channel and wraps.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            arb_idx = CH_W'((int'(last_grant_q) + k) % NUM_CH);
            if (!grant_vld && elig[arb_idx]) begin
                grant     = arb_idx;
                grant_vld = 1'b1;
            end
        end
    end

    assign pop = bus.tx_ready && grant_vld;

    always_comb begin
        push   = '0;
        pop_ch = '0;
        ovf_d  = ovf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            push[c]     = bus.datain_valid[c] && !full[c] && !bus.clr[c];
            pop_ch[c]   = pop && (grant == CH_W'(c));
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            cnt_d[c]    = cnt_q[c];
            if (bus.clr[c]) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                cnt_d[c]    = '0;
                ovf_d[c]    = 1'b0;
            end else begin
                if (push[c]) begin
                    wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
                end
                if (pop_ch[c]) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
                end
                if (bus.datain_valid[c] && full[c]) begin
                    ovf_d[c] = 1'b1;
                end
                unique case ({push[c], pop_ch[c]})
                    2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
                    2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
                    default: cnt_d[c] = cnt_q[c];
                endcase
            end
        end
    end

    always_comb begin
        dvalid_d     = pop;
        dout_d       = dout_q;
        dch_d        = dch_q;
        last_grant_d = last_grant_q;
        if (pop) begin
            dout_d       = mem_q[grant][rd_ptr_q[grant]];
            dch_d        = grant;
            last_grant_d = grant;
        end else if (bus.idle_fill && bus.tx_ready) begin
            dout_d = IDLE_WORD;
        end
    end

    // Storage has no reset; only pointers and counts define validity.
    always_ff @(posedge txusrclk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= bus.datain[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge txusrclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            ovf_q        <= '0;
            last_grant_q <= LAST_CH;
            dout_q       <= '0;
            dvalid_q     <= 1'b0;
            dch_q        <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            ovf_q        <= ovf_d;
            last_grant_q <= last_grant_d;
            dout_q       <= dout_d;
            dvalid_q     <= dvalid_d;
            dch_q        <= dch_d;
        end
    end

    assign bus.fifo_full     = full;
    assign bus.fifo_empty    = empty;
    assign bus.overflow      = ovf_q;
    assign bus.dataout       = dout_q;
    assign bus.dataout_valid = dvalid_q;
    assign bus.dataout_ch    = dch_q;

endmodule

// File: tb/tb_tx_fifo_mux.sv
// Directed bench for tx_fifo_mux: reset, fill/overflow, round-robin,
// back-pressure, flush collision and mid-stream reset.
module tb_tx_fifo_mux;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    tx_fifo_mux_if #(.DATA_W(16), .NUM_CH(4)) bus ();

    tx_fifo_mux #(
        .DATA_W(16), .DEPTH_LOG2(4), .NUM_CH(4), .IDLE_WORD(16'h50BC)
    ) dut (
        .txusrclk(clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int c, input logic [15:0] d);
        bus.datain[c*16 +: 16] = d;
        bus.datain_valid       = 4'(1 << c);
        tick();
        bus.datain_valid = '0;
    endtask

    task automatic preload4();
        for (int n = 0; n < 4; n++) begin
            bus.datain = {16'(16'hD000 + n), 16'(16'hC000 + n),
                          16'(16'hB000 + n), 16'(16'hA000 + n)};
            bus.datain_valid = 4'hF;
            tick();
        end
        bus.datain_valid = '0;
    endtask

    logic [15:0] base [4];
    logic [15:0] exp_w;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        base[0] = 16'hA000;
        base[1] = 16'hB000;
        base[2] = 16'hC000;
        base[3] = 16'hD000;
        rst_n            = 1'b0;
        bus.datain       = '0;
        bus.datain_valid = '0;
        bus.clr          = '0;
        bus.tx_ready     = 1'b1;
        bus.idle_fill    = 1'b0;

        // Reset values
        repeat (5) tick();
        check("rst_empty", 32'(bus.fifo_empty), 32'hF);
        check("rst_full", 32'(bus.fifo_full), 32'h0);
        check("rst_ovf", 32'(bus.overflow), 32'h0);
        check("rst_valid", 32'(bus.dataout_valid), 32'h0);
        check("rst_dout", 32'(bus.dataout), 32'h0);
        check("rst_ch", 32'(bus.dataout_ch), 32'h0);
        rst_n = 1'b1;
        tick();
        check("rel_valid", 32'(bus.dataout_valid), 32'h0);
        check("rel_dout", 32'(bus.dataout), 32'h0);
        bus.idle_fill = 1'b1;
        tick();
        check("idle_dout", 32'(bus.dataout), 32'h50BC);
        check("idle_valid", 32'(bus.dataout_valid), 32'h0);
        check("idle_ch", 32'(bus.dataout_ch), 32'h0);
        bus.idle_fill = 1'b0;

        // Channel 2 fill, overflow, drain
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 15; i++) put(2, 16'(i));
        check("fill15_full", 32'(bus.fifo_full), 32'h0);
        put(2, 16'h0010);
        check("fill16_full", 32'(bus.fifo_full), 32'h4);
        check("fill16_empty", 32'(bus.fifo_empty), 32'hB);
        check("fill16_ovf", 32'(bus.overflow), 32'h0);
        put(2, 16'h0011);
        check("ovf_set", 32'(bus.overflow), 32'h4);
        check("ovf_full", 32'(bus.fifo_full), 32'h4);
        check("hold_dout", 32'(bus.dataout), 32'h50BC);
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("drain_valid", 32'(bus.dataout_valid), 32'h1);
            check("drain_dout", 32'(bus.dataout), 32'(i));
            check("drain_ch", 32'(bus.dataout_ch), 32'h2);
        end
        check("drain_empty", 32'(bus.fifo_empty), 32'hF);
        tick();
        check("drain_end_valid", 32'(bus.dataout_valid), 32'h0);
        check("drain_end_dout", 32'(bus.dataout), 32'h0010);
        check("ovf_sticky", 32'(bus.overflow), 32'h4);
        bus.clr = 4'h4;
        tick();
        bus.clr = '0;
        check("ovf_clr", 32'(bus.overflow), 32'h0);

        // Round-robin across four loaded channels
        rst_n = 1'b0;
        tick();
        rst_n        = 1'b1;
        bus.tx_ready = 1'b0;
        preload4();
        check("rr_full", 32'(bus.fifo_empty), 32'h0);
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_w = base[k % 4] + 16'(k / 4);
            check("rr_valid", 32'(bus.dataout_valid), 32'h1);
            check("rr_dout", 32'(bus.dataout), 32'(exp_w));
            check("rr_ch", 32'(bus.dataout_ch), 32'(k % 4));
        end
        tick();
        check("rr_end_valid", 32'(bus.dataout_valid), 32'h0);
        check("rr_end_empty", 32'(bus.fifo_empty), 32'hF);

        // Round-robin skipping empty channel 1
        bus.tx_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            bus.datain = {16'(16'hD000 + n), 16'(16'hC000 + n),
                          16'(16'hB000 + n), 16'(16'hA000 + n)};
            bus.datain_valid = 4'b1101;
            tick();
        end
        bus.datain_valid = '0;
        bus.tx_ready     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int c;
            c = (k % 3 == 0) ? 0 : (k % 3) + 1;
            tick();
            exp_w = base[c] + 16'(k / 3);
            check("skip_dout", 32'(bus.dataout), 32'(exp_w));
            check("skip_ch", 32'(bus.dataout_ch), 32'(c));
        end
        tick();
        check("skip_end_valid", 32'(bus.dataout_valid), 32'h0);

        // Back-pressure
        bus.tx_ready = 1'b0;
        put(0, 16'h0011);
        put(0, 16'h0022);
        bus.tx_ready = 1'b1;
        tick();
        check("bp1_valid", 32'(bus.dataout_valid), 32'h1);
        check("bp1_dout", 32'(bus.dataout), 32'h0011);
        bus.tx_ready = 1'b0;
        tick();
        check("bp2_valid", 32'(bus.dataout_valid), 32'h0);
        check("bp2_dout", 32'(bus.dataout), 32'h0011);
        bus.tx_ready = 1'b1;
        tick();
        check("bp3_valid", 32'(bus.dataout_valid), 32'h1);
        check("bp3_dout", 32'(bus.dataout), 32'h0022);
        bus.tx_ready = 1'b0;
        tick();
        check("bp4_valid", 32'(bus.dataout_valid), 32'h0);
        check("bp4_dout", 32'(bus.dataout), 32'h0022);

        // Flush collision, another channel eligible
        put(3, 16'h3001);
        put(3, 16'h3002);
        put(3, 16'h3003);
        put(0, 16'h0E01);
        bus.datain[48 +: 16] = 16'hFFFF;
        bus.datain_valid     = 4'h8;
        bus.clr              = 4'h8;
        bus.tx_ready         = 1'b1;
        tick();
        bus.datain_valid = '0;
        bus.clr          = '0;
        check("fl_valid", 32'(bus.dataout_valid), 32'h1);
        check("fl_dout", 32'(bus.dataout), 32'h0E01);
        check("fl_ch", 32'(bus.dataout_ch), 32'h0);
        check("fl_empty", 32'(bus.fifo_empty), 32'hF);
        check("fl_ovf", 32'(bus.overflow), 32'h0);
        tick();
        check("fl_drop_valid", 32'(bus.dataout_valid), 32'h0);

        // Flush collision, nothing else eligible
        bus.tx_ready = 1'b0;
        put(3, 16'h3004);
        put(3, 16'h3005);
        bus.datain_valid = 4'h8;
        bus.clr          = 4'h8;
        bus.tx_ready     = 1'b1;
        tick();
        bus.datain_valid = '0;
        bus.clr          = '0;
        check("fl2_valid", 32'(bus.dataout_valid), 32'h0);
        check("fl2_empty", 32'(bus.fifo_empty), 32'hF);
        check("fl2_dout", 32'(bus.dataout), 32'h0E01);

        // Reset mid-stream
        bus.tx_ready = 1'b0;
        preload4();
        bus.tx_ready = 1'b1;
        tick();
        check("mid_dout0", 32'(bus.dataout), 32'hB000);
        tick();
        check("mid_dout1", 32'(bus.dataout), 32'hC000);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.dataout_valid), 32'h0);
        check("mid_rst_dout", 32'(bus.dataout), 32'h0);
        check("mid_rst_ch", 32'(bus.dataout_ch), 32'h0);
        check("mid_rst_empty", 32'(bus.fifo_empty), 32'hF);
        check("mid_rst_full", 32'(bus.fifo_full), 32'h0);
        tick();
        rst_n        = 1'b1;
        bus.tx_ready = 1'b0;
        put(3, 16'h3333);
        put(0, 16'h1234);
        bus.tx_ready = 1'b1;
        tick();
        check("post_rst_ch", 32'(bus.dataout_ch), 32'h0);
        check("post_rst_dout", 32'(bus.dataout), 32'h1234);
        tick();
        check("post_rst_ch2", 32'(bus.dataout_ch), 32'h3);
        check("post_rst_dout2", 32'(bus.dataout), 32'h3333);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
